// File: rtl/game_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_pkg
// Description : Shared types and constants for the game screen sequencer.
//               - screen_t : externally visible screen codes
//               - state_t  : internal sequencer state (screens plus FADE)
//               - default USB keycodes for the control keys
//               - helpers mapping between screen codes and states
// Revision    : 1.0 - initial release
// ============================================================================
package game_flow_pkg;

  typedef enum logic [2:0] {
    SCR_INTRO  = 3'd0,
    SCR_MAP    = 3'd1,
    SCR_BATTLE = 3'd2,
    SCR_PAUSE  = 3'd3,
    SCR_END    = 3'd4
  } screen_t;

  // Stable-screen states share their encoding with screen_t so the
  // conversion helpers reduce to plain relabelling.
  typedef enum logic [2:0] {
    ST_INTRO  = 3'd0,
    ST_MAP    = 3'd1,
    ST_BATTLE = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_END    = 3'd4,
    ST_FADE   = 3'd5
  } state_t;

  localparam logic [7:0] c_key_start = 8'h2C;  // space
  localparam logic [7:0] c_key_esc   = 8'h29;  // escape
  localparam logic [7:0] c_key_enter = 8'h28;  // enter
  localparam logic [7:0] c_key_cheat = 8'h05;  // 'b'
  localparam logic [7:0] c_key_pause = 8'h13;  // 'p'

  function automatic state_t screen_to_state(input screen_t scr);
    case (scr)
      SCR_INTRO:  screen_to_state = ST_INTRO;
      SCR_MAP:    screen_to_state = ST_MAP;
      SCR_BATTLE: screen_to_state = ST_BATTLE;
      SCR_PAUSE:  screen_to_state = ST_PAUSE;
      SCR_END:    screen_to_state = ST_END;
      default:    screen_to_state = ST_INTRO;
    endcase
  endfunction

  // ST_FADE has no screen of its own; callers substitute the fade target.
  function automatic screen_t state_to_screen(input state_t st);
    case (st)
      ST_INTRO:  state_to_screen = SCR_INTRO;
      ST_MAP:    state_to_screen = SCR_MAP;
      ST_BATTLE: state_to_screen = SCR_BATTLE;
      ST_PAUSE:  state_to_screen = SCR_PAUSE;
      ST_END:    state_to_screen = SCR_END;
      default:   state_to_screen = SCR_INTRO;
    endcase
  endfunction

endpackage : game_flow_pkg
`default_nettype wire

// File: rtl/game_flow_fsm_key_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_detect
// Description : Press-edge detector over a set of simultaneous USB keycode
//               slots. For every queried keycode it reports a one-cycle hit
//               when the key is present in any slot now, was absent from all
//               slots in the previous sample, and a previous sample exists.
// Ports       : Clk, Reset     - clock, synchronous active-high reset
//               keycodes       - NUM_KEYS packed 8-bit slots, 8'h00 = empty
//               i_query_keys   - NUM_QUERY packed 8-bit keycodes to watch
//               o_hit          - per-query press-edge flag (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_detect #(
  parameter int NUM_KEYS  = 2,
  parameter int NUM_QUERY = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_KEYS*8-1:0]   keycodes,
  input  logic [NUM_QUERY*8-1:0]  i_query_keys,
  output logic [NUM_QUERY-1:0]    o_hit
);

  logic [NUM_KEYS*8-1:0] r_prev_keys;
  logic                  r_prev_valid;

  // prev_valid stays low for the first post-reset cycle so a key held
  // through reset is absorbed into history instead of producing a hit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev_keys  <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_keys  <= keycodes;
      r_prev_valid <= 1'b1;
    end
  end

  for (genvar q = 0; q < NUM_QUERY; q++) begin : g_query
    logic [7:0]          w_key;
    logic [NUM_KEYS-1:0] w_now_match;
    logic [NUM_KEYS-1:0] w_prev_match;

    assign w_key = i_query_keys[q*8 +: 8];

    for (genvar s = 0; s < NUM_KEYS; s++) begin : g_slot
      assign w_now_match[s]  = (keycodes[s*8 +: 8]    == w_key);
      assign w_prev_match[s] = (r_prev_keys[s*8 +: 8] == w_key);
    end

    // A zero query would match every empty slot; it is never a key.
    assign o_hit[q] = (w_key != 8'h00) && (|w_now_match) &&
                      !(|w_prev_match) && r_prev_valid;
  end

endmodule : key_edge_detect
`default_nettype wire

// File: rtl/game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_fsm
// Description : Game screen sequencer. Walks INTRO / MAP / BATTLE / PAUSE /
//               END, inserting a timed FADE between screens (PAUSE entry and
//               exit are immediate). Screen flags are decoded from registered
//               state only.
// Ports       : Clk, Reset          - clock, synchronous active-high reset
//               keycodes            - NUM_KEYS packed keycode slots
//               enterECEB           - level, player on ECEB entrance tile
//               playerDied          - level, player HP reached 0
//               ZuofuDied           - level, boss HP reached 0
//               intro..ending       - one-hot screen flags (0 during FADE)
//               fading              - high while in FADE
//               fade_level          - remaining FADE cycles, 0 otherwise
//               screen              - current screen code / fade target
//               screen_changed      - pulse on first cycle of a new screen
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_fsm
  import game_flow_pkg::*;
#(
  parameter int         NUM_KEYS    = 2,
  parameter int         FADE_CYCLES = 16,
  parameter logic [7:0] KEY_START   = c_key_start,
  parameter logic [7:0] KEY_ESC     = c_key_esc,
  parameter logic [7:0] KEY_ENTER   = c_key_enter,
  parameter logic [7:0] KEY_CHEAT   = c_key_cheat,
  parameter logic [7:0] KEY_PAUSE   = c_key_pause
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic [NUM_KEYS*8-1:0]              keycodes,
  input  logic                               enterECEB,
  input  logic                               playerDied,
  input  logic                               ZuofuDied,
  output logic                               intro,
  output logic                               map,
  output logic                               battle,
  output logic                               paused,
  output logic                               ending,
  output logic                               fading,
  output logic [$clog2(FADE_CYCLES+1)-1:0]   fade_level,
  output logic [2:0]                         screen,
  output logic                               screen_changed
);

  localparam int FW = $clog2(FADE_CYCLES + 1);
  localparam logic [FW-1:0] c_fade_load = FW'(FADE_CYCLES);

  // Hit-vector bit positions; the query list below is packed to match.
  localparam int c_q_start = 0;
  localparam int c_q_esc   = 1;
  localparam int c_q_enter = 2;
  localparam int c_q_cheat = 3;
  localparam int c_q_pause = 4;
  localparam int c_num_q   = 5;

  logic [c_num_q*8-1:0] w_query_keys;
  logic [c_num_q-1:0]   w_hit;

  assign w_query_keys = {KEY_PAUSE, KEY_CHEAT, KEY_ENTER, KEY_ESC, KEY_START};

  key_edge_detect #(
    .NUM_KEYS  (NUM_KEYS),
    .NUM_QUERY (c_num_q)
  ) u_key_edge_detect (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycodes     (keycodes),
    .i_query_keys (w_query_keys),
    .o_hit        (w_hit)
  );

  state_t        r_state,   w_state_nxt;
  screen_t       r_target,  w_target_nxt;
  screen_t       r_resume,  w_resume_nxt;
  logic [FW-1:0] r_cnt,     w_cnt_nxt;
  logic          r_changed, w_changed_nxt;

  logic          w_go_fade;
  screen_t       w_fade_to;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_INTRO;
      r_target  <= SCR_INTRO;
      r_resume  <= SCR_MAP;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_resume  <= w_resume_nxt;
      r_cnt     <= w_cnt_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  // Each stable-screen branch either requests a FADE (w_go_fade/w_fade_to)
  // or performs an immediate PAUSE move; the FADE load is applied once at
  // the bottom so every faded transition is set up identically. Inputs are
  // not looked at in ST_FADE, which makes hits and events ignored there.
  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_resume_nxt  = r_resume;
    w_cnt_nxt     = r_cnt;
    w_changed_nxt = 1'b0;
    w_go_fade     = 1'b0;
    w_fade_to     = r_target;

    case (r_state)
      ST_INTRO: begin
        if (w_hit[c_q_start]) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_MAP;
        end
      end

      ST_MAP: begin
        if (w_hit[c_q_pause]) begin
          w_state_nxt   = ST_PAUSE;
          w_resume_nxt  = SCR_MAP;
          w_changed_nxt = 1'b1;
        end else if (w_hit[c_q_cheat] || enterECEB) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_BATTLE;
        end
      end

      ST_BATTLE: begin
        if (playerDied) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_INTRO;
        end else if (ZuofuDied) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_END;
        end else if (w_hit[c_q_pause]) begin
          w_state_nxt   = ST_PAUSE;
          w_resume_nxt  = SCR_BATTLE;
          w_changed_nxt = 1'b1;
        end else if (w_hit[c_q_esc]) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_MAP;
        end
      end

      ST_PAUSE: begin
        if (w_hit[c_q_pause]) begin
          w_state_nxt   = screen_to_state(r_resume);
          w_changed_nxt = 1'b1;
        end else if (w_hit[c_q_esc]) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_INTRO;
        end
      end

      ST_END: begin
        if (w_hit[c_q_enter]) begin
          w_go_fade = 1'b1;
          w_fade_to = SCR_INTRO;
        end
      end

      ST_FADE: begin
        // Count of 1 is the last FADE cycle; <= also recovers from a
        // zero count should one ever be seen here.
        if (r_cnt <= FW'(1)) begin
          w_state_nxt   = screen_to_state(r_target);
          w_cnt_nxt     = '0;
          w_changed_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - FW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_INTRO;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_go_fade) begin
      w_state_nxt  = ST_FADE;
      w_target_nxt = w_fade_to;
      w_cnt_nxt    = c_fade_load;
    end
  end

  assign intro          = (r_state == ST_INTRO);
  assign map            = (r_state == ST_MAP);
  assign battle         = (r_state == ST_BATTLE);
  assign paused         = (r_state == ST_PAUSE);
  assign ending         = (r_state == ST_END);
  assign fading         = (r_state == ST_FADE);
  assign fade_level     = r_cnt;
  assign screen         = (r_state == ST_FADE) ? r_target : state_to_screen(r_state);
  assign screen_changed = r_changed;

endmodule : game_flow_fsm
`default_nettype wire

// File: tb/tb_game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_flow_fsm
// Description : Directed self-checking bench for game_flow_fsm with default
//               parameters (NUM_KEYS=2, FADE_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_fsm;

  localparam int FADE = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] keycodes;
  logic        enterECEB, playerDied, ZuofuDied;
  logic        intro, map, battle, paused, ending, fading;
  logic [4:0]  fade_level;
  logic [2:0]  screen;
  logic        screen_changed;

  int n_checks = 0;
  int n_err    = 0;

  always #5 Clk = ~Clk;

  game_flow_fsm u_dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .keycodes       (keycodes),
    .enterECEB      (enterECEB),
    .playerDied     (playerDied),
    .ZuofuDied      (ZuofuDied),
    .intro          (intro),
    .map            (map),
    .battle         (battle),
    .paused         (paused),
    .ending         (ending),
    .fading         (fading),
    .fade_level     (fade_level),
    .screen         (screen),
    .screen_changed (screen_changed)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed {intro,map,battle,paused,ending,fading}.
  function automatic logic [5:0] flags();
    return {intro, map, battle, paused, ending, fading};
  endfunction

  // Press a key for one cycle, then sit out the whole FADE; returns on the
  // first cycle of the target screen.
  task automatic press_fade(input string tag, input logic [15:0] k, input logic [2:0] tgt);
    keycodes = k;
    step();
    chk({tag, "_fading"}, {fading, fade_level, screen}, {1'b1, 5'd16, tgt});
    keycodes = 16'h0000;
    repeat (FADE) step();
    chk({tag, "_arrive"}, {fading, screen, screen_changed}, {1'b0, tgt, 1'b1});
  endtask

  initial begin
    logic any_fade;
    Reset = 1'b1; keycodes = 16'h0000;
    enterECEB = 1'b0; playerDied = 1'b0; ZuofuDied = 1'b0;
    step(); step();
    chk("rst_flags", flags(), 6'b100000);
    chk("rst_level", fade_level, 5'd0);
    chk("rst_screen", screen, 3'd0);
    chk("rst_changed", screen_changed, 1'b0);
    Reset = 1'b0;
    step();  // history becomes valid here

    // 1: space in slot 0 -> FADE 16..1, MAP at n+17
    keycodes = 16'h002C;
    step();
    chk("t1_enter_fade", {flags(), fade_level, screen}, {6'b000001, 5'd16, 3'd1});
    keycodes = 16'h0000;
    for (int i = 15; i >= 1; i--) begin
      step();
      chk("t1_level", fade_level, i);
    end
    step();
    chk("t1_map", {flags(), fade_level, screen_changed}, {6'b010000, 5'd0, 1'b1});
    step();
    chk("t1_pulse_end", screen_changed, 1'b0);

    // 3: pause toggle from MAP, no FADE
    keycodes = 16'h0013;
    step();
    chk("t3_paused", {flags(), screen, screen_changed}, {6'b000100, 3'd3, 1'b1});
    keycodes = 16'h0000;
    step();
    chk("t3_hold", {flags(), screen_changed}, {6'b000100, 1'b0});
    keycodes = 16'h1300;  // slot 1 this time
    step();
    chk("t3_resume", {flags(), screen, screen_changed}, {6'b010000, 3'd1, 1'b1});
    keycodes = 16'h0000;
    step();

    // enterECEB level from MAP -> BATTLE
    enterECEB = 1'b1;
    step();
    chk("eceb_fade", {fading, screen}, {1'b1, 3'd2});
    enterECEB = 1'b0;
    repeat (FADE) step();
    chk("eceb_battle", {flags(), screen_changed}, {6'b001000, 1'b1});

    // pause in BATTLE; death ignored while paused; resume to BATTLE
    keycodes = 16'h0013;
    step();
    chk("bp_paused", flags(), 6'b000100);
    keycodes = 16'h0000; playerDied = 1'b1;
    step();
    chk("bp_death_ignored", flags(), 6'b000100);
    playerDied = 1'b0; keycodes = 16'h0013;
    step();
    chk("bp_resume", {flags(), screen}, {6'b001000, 3'd2});
    keycodes = 16'h0000;
    step();

    // 4: playerDied beats ZuofuDied and ESC
    playerDied = 1'b1; ZuofuDied = 1'b1; keycodes = 16'h0029;
    step();
    chk("t4_fade", {fading, screen}, {1'b1, 3'd0});
    playerDied = 1'b0; ZuofuDied = 1'b0; keycodes = 16'h0000;
    repeat (FADE) step();
    chk("t4_intro", {flags(), screen_changed}, {6'b100000, 1'b1});

    // 5: back to BATTLE, boss dies -> END, enter in slot 1 -> INTRO
    press_fade("t5_map", 16'h002C, 3'd1);
    press_fade("t5_battle", 16'h0005, 3'd2);
    ZuofuDied = 1'b1;
    step();
    chk("t5_end_fade", {fading, screen}, {1'b1, 3'd4});
    ZuofuDied = 1'b0;
    repeat (FADE) step();
    chk("t5_ending", flags(), 6'b000010);
    press_fade("t5_intro", 16'h2800, 3'd0);
    chk("t5_intro_flag", flags(), 6'b100000);

    // 6: reset in mid-FADE at fade_level 7
    press_fade("t6_map", 16'h002C, 3'd1);
    keycodes = 16'h0005;
    step();
    keycodes = 16'h0000;
    repeat (9) step();
    chk("t6_level7", {fading, fade_level}, {1'b1, 5'd7});
    Reset = 1'b1;
    step();
    chk("t6_reset", {flags(), fade_level, screen}, {6'b100000, 5'd0, 3'd0});

    // 2: space held through reset and 40 cycles after -> no hit
    keycodes = 16'h002C;
    step();
    Reset = 1'b0;
    any_fade = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      any_fade = any_fade | fading;
    end
    chk("t2_no_fade", any_fade, 1'b0);
    chk("t2_intro", flags(), 6'b100000);
    keycodes = 16'h0000;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_game_flow_fsm
`default_nettype wire
